// File: rtl/mmio_responder_if.sv
// mmio_responder_if: data-memory-port bus between the controller (master)
// and the MMIO responder (slave). Carries the single-cycle access strobe,
// address/write data, and the registered read data plus window-hit flag.
interface mmio_responder_if;
  logic        bus_wr;
  logic [15:0] bus_addr;
  logic [15:0] bus_din;
  logic [17:0] bus_dout;
  logic        io_hit;

  modport master (
    output bus_wr, bus_addr, bus_din,
    input  bus_dout, io_hit
  );

  modport slave (
    input  bus_wr, bus_addr, bus_din,
    output bus_dout, io_hit
  );
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: 16-word MMIO window at IO_BASE serving DISP (0x0),
// BTN_STAT (0x1) and TIMER (0x2). Read data is registered so it lines up
// with block-RAM latency; the top level muxes bus_dout using io_hit.
// Optional feature macro: IO_TIMER_EN (prescaler + TIMER at offset 0x2).
// Without it offset 0x2 reads 0 and writes to it are dropped.
module mmio_responder #(
  parameter logic [15:0] IO_BASE         = 16'h3FF0,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          PRESCALE        = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 button_raw,
  mmio_responder_if.slave      bus,
  output logic [15:0]          display,
  output logic                 btn_level
);

  logic             hit;
  logic [3:0]       off;
  logic             rd_stat;
  logic             wr_disp;
  logic [15:0]      rdata;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             evt_q, evt_d;
  logic [15:0]      disp_q, disp_d;
  logic [17:0]      dout_q, dout_d;
  logic             hit_q, hit_d;

`ifdef IO_TIMER_EN
  logic             wr_timer;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic [15:0]      timer_q, timer_d;
`else
  // The prescale setting has no effect when the timer is left out.
  logic             unused_prescale;
  assign unused_prescale = (PRESCALE >= 1);
`endif

  // Window decode and access-type qualifiers for the current bus cycle.
  always_comb begin
    hit     = (bus.bus_addr[15:4] == IO_BASE[15:4]);
    off     = bus.bus_addr[3:0];
    rd_stat = hit & ~bus.bus_wr & (off == 4'h1);
    wr_disp = hit &  bus.bus_wr & (off == 4'h0);
  end

  // Read-first data mux: always reflects register contents before this edge.
  always_comb begin
    rdata = 16'h0000;
    if (hit) begin
      case (off)
        4'h0:    rdata = disp_q;
        4'h1:    rdata = {14'b0, evt_q, level_q};
`ifdef IO_TIMER_EN
        4'h2:    rdata = timer_q;
`endif
        default: rdata = 16'h0000;
      endcase
    end
    dout_d = {2'b00, rdata};
    hit_d  = hit;
  end

  // Button synchronizer, debounce counter and sticky rising-edge event.
  always_comb begin
    sync1_d  = button_raw;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d  = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    // A new rising edge takes priority over a coincident clearing read.
    if (level_d & ~level_q) begin
      evt_d = 1'b1;
    end else if (rd_stat) begin
      evt_d = 1'b0;
    end else begin
      evt_d = evt_q;
    end
  end

  // Display register write.
  always_comb begin
    disp_d = wr_disp ? bus.bus_din : disp_q;
  end

`ifdef IO_TIMER_EN
  // Prescaled free-running timer; a bus write overrides the tick.
  always_comb begin
    wr_timer = hit & bus.bus_wr & (off == 4'h2);
    pre_d    = pre_q;
    timer_d  = timer_q;
    if (wr_timer) begin
      timer_d = bus.bus_din;
      pre_d   = '0;
    end else if (pre_q == CNT_W'(PRESCALE - 1)) begin
      pre_d   = '0;
      timer_d = timer_q + 16'd1;
    end else begin
      pre_d   = pre_q + 1'b1;
    end
  end
`endif

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      evt_q    <= 1'b0;
      disp_q   <= 16'h0000;
      dout_q   <= 18'h00000;
      hit_q    <= 1'b0;
`ifdef IO_TIMER_EN
      pre_q    <= '0;
      timer_q  <= 16'h0000;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      evt_q    <= evt_d;
      disp_q   <= disp_d;
      dout_q   <= dout_d;
      hit_q    <= hit_d;
`ifdef IO_TIMER_EN
      pre_q    <= pre_d;
      timer_q  <= timer_d;
`endif
    end
  end

  assign bus.bus_dout = dout_q;
  assign bus.io_hit   = hit_q;
  assign display      = disp_q;
  assign btn_level    = level_q;

endmodule
